// File: rtl/dpsk_vco_ctrl.sv
// -----------------------------------------------------------------------------
// dpsk_vco_ctrl
//
// Carrier-loop controller for the DPSK receiver VCO. Phase-error samples are
// run through a saturating proportional-integral filter whose output drives
// the VCO frequency offset. A 4-state FSM (IDLE/ACQ/TRACK/LOCK) tracks
// acquisition and lock. A symbol strobe is derived by counting VCO advance
// cycles.
//
// Handshake: err is consumed on every clock where err_vld=1 and the loop is
// running (state != IDLE and en=1). There is no back-pressure, so a sample
// can be accepted on every cycle.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   en           in   loop enable; low forces IDLE on the next edge
//   err_vld      in   phase-error sample valid
//   err          in   signed phase error, ERR_W bits
//   vco_rd_en    out  VCO advance enable (registered)
//   vco_dlt_step out  signed VCO frequency offset, STEP_W bits (registered)
//   sym_stb      out  one-cycle pulse per SPS advance cycles
//   locked       out  high while in LOCK (registered)
//   state        out  FSM state: IDLE=0, ACQ=1, TRACK=2, LOCK=3
// -----------------------------------------------------------------------------
module dpsk_vco_ctrl #(
    parameter int STEP_W     = 11,
    parameter int ERR_W      = 8,
    parameter int INT_W      = 16,
    parameter int KP_SHIFT   = 2,
    parameter int KI_SHIFT   = 6,
    parameter int SPS        = 8,
    parameter int ACQ_LEN    = 32,
    parameter int LOCK_THR   = 8,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     err_vld,
    input  logic signed [ERR_W-1:0]  err,
    output logic                     vco_rd_en,
    output logic signed [STEP_W-1:0] vco_dlt_step,
    output logic                     sym_stb,
    output logic                     locked,
    output logic [1:0]               state
);

    // Filter arithmetic runs two bits wider than the integrator so neither
    // the integrator sum nor the proportional+integral sum can wrap before
    // clamping.
    localparam int SUM_W   = INT_W + 2;
    localparam int ABS_W   = ERR_W + 1;
    localparam int ACQ_CW  = $clog2(ACQ_LEN + 1);
    localparam int LOCK_CW = $clog2(LOCK_CNT + 1);
    localparam int UNL_CW  = $clog2(UNLOCK_CNT + 1);
    localparam int SYM_CW  = $clog2(SPS + 1);

    localparam logic signed [SUM_W-1:0] INT_MAX  =
        {{(SUM_W-INT_W+1){1'b0}}, {(INT_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] INT_MIN  =
        {{(SUM_W-INT_W+1){1'b1}}, {(INT_W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] STEP_MAX =
        {{(SUM_W-STEP_W+1){1'b0}}, {(STEP_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] STEP_MIN =
        {{(SUM_W-STEP_W+1){1'b1}}, {(STEP_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACQ   = 2'd1,
        S_TRACK = 2'd2,
        S_LOCK  = 2'd3
    } state_t;

    state_t                    cur;
    logic signed [INT_W-1:0]   integ;
    logic [ACQ_CW-1:0]         acq_cnt;
    logic [LOCK_CW-1:0]        lock_cnt;
    logic [UNL_CW-1:0]         unl_cnt;
    logic [SYM_CW-1:0]         sym_cnt;

    logic signed [SUM_W-1:0]   err_x;
    logic signed [SUM_W-1:0]   integ_sum;
    logic signed [INT_W-1:0]   integ_n;
    logic signed [SUM_W-1:0]   integ_n_x;
    logic signed [SUM_W-1:0]   prop;
    logic signed [SUM_W-1:0]   step_sum;
    logic signed [STEP_W-1:0]  step_n;
    logic signed [ABS_W-1:0]   err_e;
    logic [ABS_W-1:0]          abs_err;
    logic                      in_thr;

    function automatic logic signed [INT_W-1:0] sat_int(
        input logic signed [SUM_W-1:0] v
    );
        if (v > INT_MAX)      return INT_MAX[INT_W-1:0];
        else if (v < INT_MIN) return INT_MIN[INT_W-1:0];
        else                  return v[INT_W-1:0];
    endfunction

    function automatic logic signed [STEP_W-1:0] sat_step(
        input logic signed [SUM_W-1:0] v
    );
        if (v > STEP_MAX)      return STEP_MAX[STEP_W-1:0];
        else if (v < STEP_MIN) return STEP_MIN[STEP_W-1:0];
        else                   return v[STEP_W-1:0];
    endfunction

    // Next integrator / step values for the current sample.
    always_comb begin
        err_x     = {{(SUM_W-ERR_W){err[ERR_W-1]}}, err};
        integ_sum = {{(SUM_W-INT_W){integ[INT_W-1]}}, integ} + err_x;
        integ_n   = sat_int(integ_sum);
        integ_n_x = {{(SUM_W-INT_W){integ_n[INT_W-1]}}, integ_n};
        // Acquisition runs with twice the proportional gain.
        if (cur == S_ACQ) prop = err_x <<< (KP_SHIFT + 1);
        else              prop = err_x <<< KP_SHIFT;
        step_sum  = prop + (integ_n_x >>> KI_SHIFT);
        step_n    = sat_step(step_sum);
    end

    // |err| one bit wider than err so the most negative code does not wrap.
    always_comb begin
        err_e   = {err[ERR_W-1], err};
        abs_err = err_e[ABS_W-1] ? -err_e : err_e;
        in_thr  = (abs_err <= ABS_W'(LOCK_THR));
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            // Reset and a dropped enable both land in a fully cleared IDLE;
            // any err_vld in this cycle is discarded.
            cur          <= S_IDLE;
            vco_rd_en    <= 1'b0;
            vco_dlt_step <= '0;
            locked       <= 1'b0;
            integ        <= '0;
            acq_cnt      <= '0;
            lock_cnt     <= '0;
            unl_cnt      <= '0;
            sym_cnt      <= '0;
        end else begin
            if (vco_rd_en) begin
                if (sym_cnt == SYM_CW'(SPS - 1)) sym_cnt <= '0;
                else                             sym_cnt <= sym_cnt + SYM_CW'(1);
            end

            case (cur)
                S_IDLE: begin
                    // Samples arriving on the start edge are not filtered.
                    cur       <= S_ACQ;
                    vco_rd_en <= 1'b1;
                end
                default: begin
                    if (err_vld) begin
                        integ        <= integ_n;
                        vco_dlt_step <= step_n;
                        case (cur)
                            S_ACQ: begin
                                if (acq_cnt == ACQ_CW'(ACQ_LEN - 1)) begin
                                    cur     <= S_TRACK;
                                    acq_cnt <= '0;
                                end else begin
                                    acq_cnt <= acq_cnt + ACQ_CW'(1);
                                end
                            end
                            S_TRACK: begin
                                if (!in_thr) begin
                                    lock_cnt <= '0;
                                end else if (lock_cnt == LOCK_CW'(LOCK_CNT - 1)) begin
                                    cur      <= S_LOCK;
                                    locked   <= 1'b1;
                                    lock_cnt <= '0;
                                end else begin
                                    lock_cnt <= lock_cnt + LOCK_CW'(1);
                                end
                            end
                            S_LOCK: begin
                                if (in_thr) begin
                                    unl_cnt <= '0;
                                end else if (unl_cnt == UNL_CW'(UNLOCK_CNT - 1)) begin
                                    cur     <= S_TRACK;
                                    locked  <= 1'b0;
                                    unl_cnt <= '0;
                                end else begin
                                    unl_cnt <= unl_cnt + UNL_CW'(1);
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign sym_stb = vco_rd_en && (sym_cnt == SYM_CW'(SPS - 1));
    assign state   = cur;

endmodule

// File: tb/tb_dpsk_vco_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for dpsk_vco_ctrl: directed scenarios followed by randomized traffic,
// every cycle compared against an arithmetic reference model of the loop.
// -----------------------------------------------------------------------------
module tb_dpsk_vco_ctrl;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               err_vld;
    logic signed [7:0]  err;
    logic               vco_rd_en;
    logic signed [10:0] vco_dlt_step;
    logic               sym_stb;
    logic               locked;
    logic [1:0]         state;

    int checks = 0;
    int errors = 0;

    // Reference model: plain integers, state as a number 0..3.
    int m_state = 0;
    int m_integ = 0;
    int m_step  = 0;
    int m_acq   = 0;
    int m_in    = 0;
    int m_out   = 0;
    int m_sym   = 0;   // index of the current advance cycle since leaving IDLE

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    dpsk_vco_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .err_vld      (err_vld),
        .err          (err),
        .vco_rd_en    (vco_rd_en),
        .vco_dlt_step (vco_dlt_step),
        .sym_stb      (sym_stb),
        .locked       (locked),
        .state        (state)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic signed [31:0] got, input int exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Floor division by 64 (arithmetic right shift by 6).
    function automatic int fdiv64(input int v);
        int q;
        q = v / 64;
        if (v < 0 && q * 64 != v) q = q - 1;
        return q;
    endfunction

    task automatic model_edge(input bit r, input bit e, input bit v, input int ev);
        int mag;
        if (r || !e) begin
            m_state = 0; m_integ = 0; m_step = 0;
            m_acq = 0; m_in = 0; m_out = 0; m_sym = 0;
            return;
        end
        if (m_state != 0) m_sym++;
        if (m_state == 0) begin
            m_state = 1;
            return;
        end
        if (!v) return;
        m_integ = clamp(m_integ + ev, -32768, 32767);
        m_step  = clamp(ev * ((m_state == 1) ? 8 : 4) + fdiv64(m_integ), -1024, 1023);
        mag = (ev < 0) ? -ev : ev;
        case (m_state)
            1: begin
                m_acq++;
                if (m_acq == 32) begin m_state = 2; m_acq = 0; end
            end
            2: begin
                if (mag <= 8) m_in++; else m_in = 0;
                if (m_in == 16) begin m_state = 3; m_in = 0; end
            end
            3: begin
                if (mag > 8) m_out++; else m_out = 0;
                if (m_out == 4) begin m_state = 2; m_out = 0; end
            end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        check("state",   state,        m_state);
        check("locked",  locked,       (m_state == 3) ? 1 : 0);
        check("rd_en",   vco_rd_en,    (m_state != 0) ? 1 : 0);
        check("step",    vco_dlt_step, m_step);
        check("sym_stb", sym_stb,      (m_state != 0 && (m_sym % 8) == 7) ? 1 : 0);
    endtask

    // ---------------- driver ----------------
    task automatic cyc(input bit r, input bit e, input bit v, input int ev);
        rst     = r;
        en      = e;
        err_vld = v;
        err     = ev[7:0];
        @(posedge clk);
        model_edge(r, e, v, ev);
        #1;
        compare_all();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n_stb;
        int sat_exp[5];
        int ev;
        sat_exp = '{1017, 1019, 1021, 1023, 1023};

        rst = 1'b1; en = 1'b1; err_vld = 1'b0; err = '0;

        // Reset held with en=1.
        repeat (3) cyc(1, 1, 0, 0);
        check("rst_state", state, 0);
        check("rst_step", vco_dlt_step, 0);
        check("rst_rd_en", vco_rd_en, 0);

        // Release: ACQ one edge later, strobe every 8 advance cycles.
        cyc(0, 1, 0, 0);
        check("start_state", state, 1);
        check("start_rd_en", vco_rd_en, 1);
        n_stb = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, 0, 0);
            if (sym_stb) n_stb++;
        end
        check("sym_stb_count", n_stb, 2);

        // ACQ saturation with +127.
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 1, 127);
            check("acq_sat_pos", vco_dlt_step, sat_exp[i]);
        end
        // err_vld while en falls is dropped.
        cyc(0, 0, 1, 50);
        check("en_fall_step", vco_dlt_step, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 1, -128);
        check("acq_sat_neg", vco_dlt_step, -1024);

        // Acquisition length: 31 samples then abort.
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        repeat (31) cyc(0, 1, 1, 0);
        check("acq31_state", state, 1);
        cyc(0, 0, 0, 0);
        check("abort_state", state, 0);
        check("abort_step", vco_dlt_step, 0);
        // Sample on the start edge is ignored.
        cyc(0, 1, 1, 5);
        check("start_vld_step", vco_dlt_step, 0);
        repeat (31) cyc(0, 1, 1, 0);
        check("acq31b_state", state, 1);
        cyc(0, 1, 1, 0);
        check("acq32_state", state, 2);

        // TRACK gain.
        cyc(0, 1, 1, 10);
        check("track_p10", vco_dlt_step, 40);
        cyc(0, 1, 0, 0);
        check("track_hold", vco_dlt_step, 40);
        cyc(0, 1, 1, -10);
        check("track_m10", vco_dlt_step, -40);

        // Lock: interrupted run does not lock.
        repeat (15) cyc(0, 1, 1, 3);
        cyc(0, 1, 1, 20);
        repeat (15) cyc(0, 1, 1, 3);
        check("lock_pre", locked, 0);
        cyc(0, 1, 1, 3);
        check("lock_rise", locked, 1);
        check("lock_state", state, 3);

        // Unlock: interrupted run does not unlock.
        repeat (3) cyc(0, 1, 1, 20);
        cyc(0, 1, 1, 0);
        repeat (3) cyc(0, 1, 1, -20);
        check("unlock_pre", locked, 1);
        cyc(0, 1, 1, -20);
        check("unlock_fall", locked, 0);
        check("unlock_state", state, 2);

        // Threshold boundary: 8 is in, -9 is out, -128 is out.
        repeat (15) cyc(0, 1, 1, 8);
        cyc(0, 1, 1, -9);
        repeat (15) cyc(0, 1, 1, 8);
        check("abs_pre", state, 2);
        cyc(0, 1, 1, 8);
        check("abs_lock", state, 3);
        repeat (3) cyc(0, 1, 1, -128);
        check("m128_pre", state, 3);
        cyc(0, 1, 1, -128);
        check("m128_unlock", state, 2);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) < 7) ev = int'($urandom_range(0, 18)) - 9;
            else                          ev = int'($urandom_range(0, 255)) - 128;
            cyc(($urandom_range(0, 299) == 0),
                ($urandom_range(0, 63) != 0),
                ($urandom_range(0, 3) != 0),
                ev);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpsk_vco_ctrl.md
# dpsk_vco_ctrl

Loop controller that sequences the carrier VCO in the DPSK receiver. It turns phase-error samples from the phase detector into the VCO's `rd_en` / `dlt_step` controls through a saturating proportional-integral loop filter. It tracks acquisition and lock with a 4-state FSM and emits a symbol strobe derived from VCO advance cycles. It sits between the phase detector and the `vco` instance, driving all VCO control inputs.

## Interface
- `STEP_W`, 11: width of `vco_dlt_step`; must match the VCO `dlt_step` port.
- `ERR_W`, 8: width of the signed phase-error input.
- `INT_W`, 16: integrator width, signed.
- `KP_SHIFT`, 2: proportional gain, applied as a left shift; acquisition uses `KP_SHIFT+1`.
- `KI_SHIFT`, 6: integral path scaling, applied as an arithmetic right shift of the integrator.
- `SPS`, 8: VCO advance cycles per symbol.
- `ACQ_LEN`, 32: number of `err_vld` samples spent in ACQ.
- `LOCK_THR`, 8: lock threshold on |err|.
- `LOCK_CNT`, 16: consecutive in-threshold samples needed to enter LOCK.
- `UNLOCK_CNT`, 4: consecutive out-of-threshold samples needed to leave LOCK.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `en` in 1: loop enable.
- `err_vld` in 1: phase-error sample valid.
- `err` in ERR_W, signed: phase error.
- `vco_rd_en` out 1: VCO advance enable, connects to the VCO `rd_en`.
- `vco_dlt_step` out STEP_W, signed: VCO frequency offset, connects to the VCO `dlt_step`.
- `sym_stb` out 1: one-cycle pulse per symbol.
- `locked` out 1: high while in LOCK.
- `state` out 2: IDLE=0, ACQ=1, TRACK=2, LOCK=3.

## Operation
- FSM transitions:
  - IDLE→ACQ when `en`=1.
  - ACQ→TRACK on the `err_vld` that completes `ACQ_LEN` samples.
  - TRACK→LOCK on the `LOCK_CNT`-th consecutive sample with |err|≤`LOCK_THR`.
  - LOCK→TRACK on the `UNLOCK_CNT`-th consecutive sample with |err|>`LOCK_THR`.
- Any sample on the wrong side of the threshold clears the relevant consecutive counter.
- `en`=0 in any state forces IDLE on the next edge. Entering IDLE clears the integrator, all counters, `vco_dlt_step`, and the symbol counter.
- `vco_rd_en` = 1 in ACQ/TRACK/LOCK and 0 in IDLE. It is registered.
- Loop filter, evaluated only when `err_vld`=1 and not in IDLE:
  - `integ_n` = sat_INT(`integ` + sext(`err`)).
  - `prop` = sext(`err`) <<< (ACQ ? `KP_SHIFT`+1 : `KP_SHIFT`).
  - `vco_dlt_step` ← sat_STEP(`prop` + (`integ_n` >>> `KI_SHIFT`)).
  - All sums are computed at `INT_W`+2 bits before clamping.
  - sat_INT clamps to [-32768, 32767]; sat_STEP clamps to [-1024, 1023].
- Without `err_vld`, `vco_dlt_step` and `integ` hold.
- |err| is computed at ERR_W+1 bits, so |-128| = 128 with no wrap.
- Symbol counter: counts 0..`SPS`-1 on each cycle `vco_rd_en`=1 and wraps to 0. `sym_stb`=1 in the cycle the count equals `SPS`-1.
- `err_vld` in the same cycle as the IDLE→ACQ transition is ignored.
- `err_vld` in the cycle `en` falls is ignored.

## Timing
- Reset values: `vco_rd_en`=0, `vco_dlt_step`=0, `sym_stb`=0, `locked`=0, `state`=0. Integrator and all counters are 0.
- `rst` mid-operation overrides `en` and returns to IDLE on the same edge.
- Control latency:
  - `en` rising at edge k → `state`=ACQ and `vco_rd_en`=1 after edge k.
  - First `sym_stb` is high during the `SPS`-th cycle with `vco_rd_en`=1.
- Filter latency: `err_vld` sampled at edge n → `vco_dlt_step` updated after edge n, i.e. valid from cycle n+1. The update includes sample n.
- `state` and `locked` change on the same edge as the qualifying `err_vld` sample. `locked` = (`state`==LOCK), registered.
- Back-to-back `err_vld` every cycle is supported with no bubbles.

## Test plan
- Reset and idle: assert `rst` for 3 cycles with `en`=1 → all outputs 0. After release, `state`=1 and `vco_rd_en`=1 one cycle later; `sym_stb` pulses every 8 cycles.
- TRACK gain, with integ=0: single `err`=+10 → `vco_dlt_step`=40 next cycle and held. Next `err`=-10 → integ 0, step -40.
- ACQ saturation: `err`=127 every cycle from ACQ entry → steps 1017, 1019, 1021, 1023, 1023. `err`=-128 from a cleared state → -1024.
- Acquisition length: 32 `err_vld` pulses with `err`=0 → `state`=2 on the 32nd. 31 pulses followed by `en`=0 → IDLE, step 0.
- Lock and unlock:
  - In TRACK, 15× `err`=3, 1× `err`=20, then 16× `err`=3 → `locked` rises only on the final sample.
  - Then 3× `err`=20, 1× `err`=0, 4× `err`=-20 → `locked` falls on the last sample and `state`=2.
- Abs boundary: in TRACK, `err`=8 counts as in-lock; `err`=-9 counts as out. In LOCK, `err`=-128 with no wrap counts as out-of-threshold.
